game_state_ctrl: RTL and testbench

//  Frame-level game referee that sits between the pixel-rate object generators and the colour mux.

---
 rtl/game_state_ctrl.sv | 154 +++++++++++++++
 tb/tb_game_state_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Frame-level game referee: counts per-frame player overlaps with walls/border and end zone,
// then resolves them on each frame tick into PLAY / HIT / WIN / LOSE with lives and a frame countdown.
//
// state | meaning
// PLAY  | normal play, overlap pixels accumulate
// HIT   | player invulnerable after a non-fatal hit, counts down invuln frames
// WIN   | goal reached, sticky until restart
// LOSE  | out of lives or time, sticky until restart
module game_state_ctrl #(
    parameter int WALL_W        = 115,
    parameter int LIVES         = 3,
    parameter int HIT_THRESH    = 4,
    parameter int INVULN_FRAMES = 30,
    parameter int TIME_LIMIT    = 3600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update,
    input  logic              player,
    input  logic [WALL_W-1:0] walls,
    input  logic              border,
    input  logic              end_zone,
    input  logic              levelselect,
    input  logic              restart,
    output logic [1:0]        state,
    output logic              win,
    output logic              game_over,
    output logic [1:0]        lives,
    output logic [11:0]       time_left,
    output logic              respawn
);

    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [11:0] TIME_INIT  = 12'(TIME_LIMIT);
    localparam logic [7:0]  INV_INIT   = 8'(INVULN_FRAMES);
    localparam logic [7:0]  HIT_TH     = 8'(HIT_THRESH);

    typedef enum logic [1:0] {
        PLAY = 2'b00,
        HIT  = 2'b01,
        WIN  = 2'b10,
        LOSE = 2'b11
    } state_t;

    state_t      state_q, state_n;
    logic [1:0]  lives_q, lives_n;
    logic [11:0] time_q, time_n;
    logic [7:0]  hit_q, hit_n, goal_q, goal_n, inv_q, inv_n;
    logic        resp_q, resp_n;
    logic        win_q, over_q;
    logic        level_q;
    logic        restart_req;

    assign restart_req = (levelselect != level_q) ||
                         (restart && (state_q == WIN || state_q == LOSE));

    always_comb begin
        state_n = state_q;
        lives_n = lives_q;
        time_n  = time_q;
        hit_n   = hit_q;
        goal_n  = goal_q;
        inv_n   = inv_q;
        resp_n  = 1'b0;
        if (restart_req) begin
            state_n = PLAY;
            lives_n = LIVES_INIT;
            time_n  = TIME_INIT;
            hit_n   = 8'd0;
            goal_n  = 8'd0;
            inv_n   = 8'd0;
            resp_n  = 1'b1;
        end else if (update) begin
            hit_n  = 8'd0;
            goal_n = 8'd0;
            case (state_q)
                PLAY: begin
                    if (hit_q >= HIT_TH) begin
                        lives_n = lives_q - 2'd1;
                        if (lives_q <= 2'd1) begin
                            state_n = LOSE;
                            lives_n = 2'd0;
                        end else begin
                            state_n = HIT;
                            inv_n   = INV_INIT;
                            resp_n  = 1'b1;
                        end
                    end else if (goal_q != 8'd0) begin
                        state_n = WIN;
                    end else if (time_q == 12'd0) begin
                        state_n = LOSE;
                    end else begin
                        time_n = time_q - 12'd1;
                    end
                end
                HIT: begin
                    if (time_q == 12'd0) begin
                        state_n = LOSE;
                    end else begin
                        time_n = time_q - 12'd1;
                        inv_n  = inv_q - 8'd1;
                        if (inv_q <= 8'd1) begin
                            state_n = PLAY;
                            inv_n   = 8'd0;
                        end
                    end
                end
                default: ;
            endcase
        end else if (state_q == PLAY) begin
            // Saturating per-frame overlap counters
            if (player && ((|walls) || border) && hit_q != 8'hFF)
                hit_n = hit_q + 8'd1;
            if (player && end_zone && goal_q != 8'hFF)
                goal_n = goal_q + 8'd1;
        end else begin
            hit_n  = 8'd0;
            goal_n = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        level_q <= levelselect;
        if (rst) begin
            state_q <= PLAY;
            lives_q <= LIVES_INIT;
            time_q  <= TIME_INIT;
            hit_q   <= 8'd0;
            goal_q  <= 8'd0;
            inv_q   <= 8'd0;
            resp_q  <= 1'b0;
            win_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            lives_q <= lives_n;
            time_q  <= time_n;
            hit_q   <= hit_n;
            goal_q  <= goal_n;
            inv_q   <= inv_n;
            resp_q  <= resp_n;
            win_q   <= (state_n == WIN);
            over_q  <= (state_n == LOSE);
        end
    end

    assign state     = state_q;
    assign win       = win_q;
    assign game_over = over_q;
    assign lives     = lives_q;
    assign time_left = time_q;
    assign respawn   = resp_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: two instances (default and short time limit) checked every cycle
// against a frame-rule model, plus directed literal checks of the key scenarios.
module tb_game_state_ctrl;
    localparam int W = 115;

    logic clk = 1'b0, rst = 1'b1, update = 1'b0, player = 1'b0, border = 1'b0;
    logic end_zone = 1'b0, levelselect = 1'b0, restart = 1'b0;
    logic [W-1:0] walls = '0;

    logic [1:0]  st_a, lv_a, st_b, lv_b;
    logic        win_a, go_a, rsp_a, win_b, go_b, rsp_b;
    logic [11:0] tl_a, tl_b;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    game_state_ctrl #(.WALL_W(W)) dut_a (
        .clk(clk), .rst(rst), .update(update), .player(player), .walls(walls),
        .border(border), .end_zone(end_zone), .levelselect(levelselect), .restart(restart),
        .state(st_a), .win(win_a), .game_over(go_a), .lives(lv_a), .time_left(tl_a),
        .respawn(rsp_a));

    game_state_ctrl #(.WALL_W(W), .TIME_LIMIT(5)) dut_b (
        .clk(clk), .rst(rst), .update(update), .player(player), .walls(walls),
        .border(border), .end_zone(end_zone), .levelselect(levelselect), .restart(restart),
        .state(st_b), .win(win_b), .game_over(go_b), .lives(lv_b), .time_left(tl_b),
        .respawn(rsp_b));

    // st: 0 PLAY, 1 HIT, 2 WIN, 3 LOSE
    typedef struct {
        int st, lives, tl, hc, gc, inv, resp, lvl;
    } mdl_t;

    mdl_t ma, mb;
    bit   mvalid = 0;

    function automatic mdl_t step(mdl_t m, int tlim, bit r, bit u, bit hp, bit gp, bit lv, bit rs);
        mdl_t n = m;
        n.resp = 0;
        n.lvl  = lv;
        if (r) begin
            n.st = 0; n.lives = 3; n.tl = tlim; n.hc = 0; n.gc = 0; n.inv = 0;
        end else if (lv != m.lvl || (rs && m.st >= 2)) begin
            n.st = 0; n.lives = 3; n.tl = tlim; n.hc = 0; n.gc = 0; n.inv = 0; n.resp = 1;
        end else if (u) begin
            n.hc = 0; n.gc = 0;
            if (m.st == 0) begin
                if (m.hc >= 4) begin
                    n.lives = m.lives - 1;
                    if (n.lives == 0) n.st = 3;
                    else begin n.st = 1; n.inv = 30; n.resp = 1; end
                end else if (m.gc > 0) n.st = 2;
                else if (m.tl == 0) n.st = 3;
                else n.tl = m.tl - 1;
            end else if (m.st == 1) begin
                if (m.tl == 0) n.st = 3;
                else begin
                    n.tl = m.tl - 1;
                    n.inv = m.inv - 1;
                    if (n.inv == 0) n.st = 0;
                end
            end
        end else if (m.st == 0) begin
            if (hp) n.hc = (m.hc >= 255) ? 255 : m.hc + 1;
            if (gp) n.gc = (m.gc >= 255) ? 255 : m.gc + 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        bit hp, gp;
        hp = player && ((|walls) || border);
        gp = player && end_zone;
        ma <= step(ma, 3600, rst, update, hp, gp, levelselect, restart);
        mb <= step(mb, 5,    rst, update, hp, gp, levelselect, restart);
        if (rst) mvalid <= 1;
    end

    task automatic cmp(string nm, logic [1:0] st, logic w, logic go, logic [1:0] lv,
                       logic [11:0] tl, logic rsp, mdl_t m);
        nvec++;
        if (st !== 2'(m.st) || w !== (m.st == 2) || go !== (m.st == 3) ||
            lv !== 2'(m.lives) || tl !== 12'(m.tl) || rsp !== 1'(m.resp)) begin
            nmis++;
            $display("FAIL %s t=%0t got st=%0d win=%0b go=%0b lives=%0d tl=%0d rsp=%0b expected st=%0d lives=%0d tl=%0d rsp=%0d",
                     nm, $time, st, w, go, lv, tl, rsp, m.st, m.lives, m.tl, m.resp);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            cmp("model_a", st_a, win_a, go_a, lv_a, tl_a, rsp_a, ma);
            cmp("model_b", st_b, win_b, go_b, lv_b, tl_b, rsp_b, mb);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic upd();
        update = 1'b1;
        cyc(1);
        update = 1'b0;
    endtask

    // One frame of overlap pixels: wall, border and end-zone hits, each on its own pixel
    task automatic frame(int wpx, int bpx, int gpx);
        for (int i = 0; i < wpx; i++) begin
            player = 1'b1; walls[$urandom_range(W-1, 0)] = 1'b1; cyc(1);
            player = 1'b0; walls = '0;
        end
        for (int i = 0; i < bpx; i++) begin
            player = 1'b1; border = 1'b1; cyc(1);
            player = 1'b0; border = 1'b0;
        end
        for (int i = 0; i < gpx; i++) begin
            player = 1'b1; end_zone = 1'b1; cyc(1);
            player = 1'b0; end_zone = 1'b0;
        end
        border = 1'b1; cyc(1); border = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("rst_state", st_a, 0);
        chk("rst_lives", lv_a, 3);
        chk("rst_time_a", tl_a, 3600);
        chk("rst_time_b", tl_b, 5);
        chk("rst_flags", {win_a, go_a, rsp_a}, 0);
        rst = 1'b0;
        cyc(1);

        // time limit expiry on the short instance
        repeat (5) begin upd(); cyc(2); end
        chk("t4_time_b", tl_b, 0);
        chk("t4_state_b_play", st_b, 0);
        chk("t4_time_a", tl_a, 3595);
        upd();
        chk("t4_state_b_lose", st_b, 3);
        chk("t4_over_b", go_b, 1);
        upd(); upd();
        chk("t4_time_b_hold", tl_b, 0);
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);

        // 3 px below threshold; the pixel on the update cycle itself is not counted
        frame(3, 0, 0);
        player = 1'b1; walls[7] = 1'b1;
        upd();
        player = 1'b0; walls = '0;
        chk("t2_state", st_a, 0);
        chk("t2_lives", lv_a, 3);
        chk("t2_time", tl_a, 3599);

        // 4 px hit, then 30 invulnerable frames
        frame(4, 0, 0);
        upd();
        chk("t1_state_hit", st_a, 1);
        chk("t1_lives", lv_a, 2);
        chk("t1_respawn", rsp_a, 1);
        cyc(1);
        chk("t1_respawn_end", rsp_a, 0);
        repeat (29) begin frame(2, 2, 1); upd(); end
        chk("t1_still_hit", st_a, 1);
        frame(0, 0, 0);
        upd();
        chk("t1_back_play", st_a, 0);

        // saturating hit, then fatal hit beating a goal in the same frame
        frame(300, 0, 0);
        upd();
        chk("sat_hit_lives", lv_a, 1);
        repeat (30) begin upd(); cyc(1); end
        chk("t3_play", st_a, 0);
        frame(0, 10, 5);
        upd();
        chk("t3_lose", st_a, 3);
        chk("t3_over", go_a, 1);
        chk("t3_lives", lv_a, 0);
        upd();
        chk("t3_sticky", st_a, 3);

        // restart from LOSE, reach WIN, restart from WIN, restart ignored in PLAY
        restart = 1'b1; cyc(1); restart = 1'b0;
        chk("t5_rs_lose_state", st_a, 0);
        chk("t5_rs_lose_lives", lv_a, 3);
        frame(0, 0, 1);
        upd();
        chk("t5_win", st_a, 2);
        chk("t5_win_flag", win_a, 1);
        upd();
        chk("t5_win_sticky", st_a, 2);
        restart = 1'b1; cyc(1); restart = 1'b0;
        chk("t5_rs_state", st_a, 0);
        chk("t5_rs_lives", lv_a, 3);
        chk("t5_rs_time", tl_a, 3600);
        chk("t5_rs_respawn", rsp_a, 1);
        cyc(1);
        restart = 1'b1; cyc(1); restart = 1'b0;
        chk("t5_play_ignore", {st_a, 11'(0), rsp_a}, 0);
        chk("t5_play_time", tl_a, 3600);

        // level change beats same-cycle update in HIT, then rst mid-frame
        frame(5, 0, 0);
        upd();
        chk("t6_hit", st_a, 1);
        levelselect = ~levelselect;
        upd();
        chk("t6_lvl_state", st_a, 0);
        chk("t6_lvl_lives", lv_a, 3);
        chk("t6_lvl_time", tl_a, 3600);
        chk("t6_lvl_respawn", rsp_a, 1);
        player = 1'b1; border = 1'b1;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_vals", {st_a, lv_a, tl_a, win_a, go_a, rsp_a}, {2'd0, 2'd3, 12'd3600, 3'b000});
        rst = 1'b0; player = 1'b0; border = 1'b0;
        cyc(1);
        upd();
        chk("t6_after_rst_state", st_a, 0);
        chk("t6_after_rst_time", tl_a, 3599);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
